// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - IF/ID stage bundle: fetch and EX inputs, decode-side outputs
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      Instruction_if;
  logic [31:0]      PC_if;
  logic             IF_flush;
  logic             MemRead_ex;
  logic [4:0]       Rd_ex;
  logic [31:0]      Instruction_id;
  logic [31:0]      PC_id;
  logic             Valid_id;
  logic [4:0]       Rs1_id;
  logic [4:0]       Rs2_id;
  logic [4:0]       Rd_id;
  logic             IFWrite;
  logic             Bubble_id;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Instruction_if, PC_if, IF_flush, MemRead_ex, Rd_ex,
    input  Instruction_id, PC_id, Valid_id, Rs1_id, Rs2_id, Rd_id,
    input  IFWrite, Bubble_id, StallCount, FlushCount
  );

  modport slave (
    input  Instruction_if, PC_if, IF_flush, MemRead_ex, Rd_ex,
    output Instruction_id, PC_id, Valid_id, Rs1_id, Rs2_id, Rd_id,
    output IFWrite, Bubble_id, StallCount, FlushCount
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use hazard detection and event counters
module if_id_stage #(
  parameter logic [31:0] NOP   = 32'h00000013,
  parameter int          CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  if_id_stage_if.slave bus
);

  logic [31:0]      instr_q;
  logic [31:0]      pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;
  logic             bubble;
  logic [4:0]       rs1;
  logic [4:0]       rs2;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr_q[6:0])
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: uses_rs1 = 1'b1;
      7'b0000011: uses_rs1 = 1'b1;
      7'b1100111: uses_rs1 = 1'b1;
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // Only registered ID state and same-cycle EX inputs feed the hazard; fetch data never does.
  assign hazard = valid_q && bus.MemRead_ex && (bus.Rd_ex != 5'd0) &&
                  ((uses_rs1 && (bus.Rd_ex == rs1)) || (uses_rs2 && (bus.Rd_ex == rs2)));
  assign bubble = hazard && !bus.IF_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else if (bus.IF_flush) begin
      instr_q <= NOP;
      pc_q    <= bus.PC_if;
      valid_q <= 1'b0;
    end else if (!hazard) begin
      instr_q <= bus.Instruction_if;
      pc_q    <= bus.PC_if;
      valid_q <= 1'b1;
    end
  end

  // Saturating debug counters; a flush masks the bubble so both never count together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (bubble && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (bus.IF_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.Instruction_id = instr_q;
  assign bus.PC_id          = pc_q;
  assign bus.Valid_id       = valid_q;
  assign bus.Rs1_id         = rs1;
  assign bus.Rs2_id         = rs2;
  assign bus.Rd_id          = instr_q[11:7];
  assign bus.IFWrite        = !hazard || bus.IF_flush;
  assign bus.Bubble_id      = bubble;
  assign bus.StallCount     = stall_count;
  assign bus.FlushCount     = flush_count;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

  localparam logic [31:0] NOP_W  = 32'h00000013;
  localparam logic [31:0] ADDI_W = 32'h00500093;
  localparam logic [31:0] ADD_W  = 32'h002081B3;
  localparam logic [31:0] SW_W   = 32'h00302023;
  localparam logic [31:0] LUI_W  = 32'h000122B7;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  if_id_stage_if #(.CNT_W(16)) bus ();

  if_id_stage #(.NOP(NOP_W), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.Instruction_if = 32'h0;
    bus.PC_if          = 32'h0;
    bus.IF_flush       = 1'b0;
    bus.MemRead_ex     = 1'b0;
    bus.Rd_ex          = 5'd0;

    // Reset held for two cycles
    tick();
    tick();
    check("rst_instr", bus.Instruction_id, NOP_W);
    check("rst_pc", bus.PC_id, 32'h0);
    check("rst_valid", {31'b0, bus.Valid_id}, 32'h0);
    check("rst_ifwrite", {31'b0, bus.IFWrite}, 32'h1);
    check("rst_bubble", {31'b0, bus.Bubble_id}, 32'h0);
    check("rst_stall", {16'b0, bus.StallCount}, 32'h0);
    check("rst_flush", {16'b0, bus.FlushCount}, 32'h0);

    // Stream starts
    reset = 1'b1;
    bus.Instruction_if = ADDI_W;
    bus.PC_if = 32'h0;
    tick();
    check("s1_instr", bus.Instruction_id, ADDI_W);
    check("s1_pc", bus.PC_id, 32'h0);
    check("s1_valid", {31'b0, bus.Valid_id}, 32'h1);

    // Load-use on rs2
    bus.Instruction_if = ADD_W;
    bus.PC_if = 32'h4;
    tick();
    check("add_instr", bus.Instruction_id, ADD_W);
    bus.Instruction_if = SW_W;
    bus.PC_if = 32'h8;
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd2;
    #1;
    check("lu_ifwrite", {31'b0, bus.IFWrite}, 32'h0);
    check("lu_bubble", {31'b0, bus.Bubble_id}, 32'h1);
    check("lu_rs1", {27'b0, bus.Rs1_id}, 32'd1);
    check("lu_rs2", {27'b0, bus.Rs2_id}, 32'd2);
    check("lu_rd", {27'b0, bus.Rd_id}, 32'd3);
    tick();
    check("lu_hold_instr", bus.Instruction_id, ADD_W);
    check("lu_hold_pc", bus.PC_id, 32'h4);
    check("lu_stall", {16'b0, bus.StallCount}, 32'd1);
    bus.MemRead_ex = 1'b0;
    #1;
    check("lu_release", {31'b0, bus.IFWrite}, 32'h1);
    tick();
    check("lu_adv_instr", bus.Instruction_id, SW_W);
    check("lu_adv_pc", bus.PC_id, 32'h8);
    check("lu_stall_keep", {16'b0, bus.StallCount}, 32'd1);

    // No false hazard: Rd_ex = 0 against sw (rs1 = x0)
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd0;
    #1;
    check("rd0_ifwrite", {31'b0, bus.IFWrite}, 32'h1);
    check("rd0_bubble", {31'b0, bus.Bubble_id}, 32'h0);

    // lui x5: bits [19:15] = 2 but no source operand
    bus.MemRead_ex = 1'b0;
    bus.Instruction_if = LUI_W;
    bus.PC_if = 32'hC;
    tick();
    check("lui_instr", bus.Instruction_id, LUI_W);
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd2;
    #1;
    check("lui_ifwrite", {31'b0, bus.IFWrite}, 32'h1);
    check("lui_bubble", {31'b0, bus.Bubble_id}, 32'h0);

    // Flush, then check that an invalid slot never stalls
    bus.MemRead_ex = 1'b0;
    bus.IF_flush = 1'b1;
    bus.PC_if = 32'h10;
    tick();
    check("fl_instr", bus.Instruction_id, NOP_W);
    check("fl_valid", {31'b0, bus.Valid_id}, 32'h0);
    check("fl_pc", bus.PC_id, 32'h10);
    check("fl_count", {16'b0, bus.FlushCount}, 32'd1);
    bus.IF_flush = 1'b0;
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd1;
    #1;
    check("inv_ifwrite", {31'b0, bus.IFWrite}, 32'h1);

    // Flush coincident with a real hazard
    bus.MemRead_ex = 1'b0;
    bus.Instruction_if = ADD_W;
    bus.PC_if = 32'h14;
    tick();
    check("fh_load", bus.Instruction_id, ADD_W);
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd1;
    bus.IF_flush = 1'b1;
    bus.Instruction_if = SW_W;
    bus.PC_if = 32'h18;
    #1;
    check("fh_ifwrite", {31'b0, bus.IFWrite}, 32'h1);
    check("fh_bubble", {31'b0, bus.Bubble_id}, 32'h0);
    tick();
    check("fh_instr", bus.Instruction_id, NOP_W);
    check("fh_valid", {31'b0, bus.Valid_id}, 32'h0);
    check("fh_flush", {16'b0, bus.FlushCount}, 32'd2);
    check("fh_stall", {16'b0, bus.StallCount}, 32'd1);

    // Back-to-back flush keeps Valid_id low
    tick();
    check("bb_valid", {31'b0, bus.Valid_id}, 32'h0);
    check("bb_flush", {16'b0, bus.FlushCount}, 32'd3);

    // Asynchronous reset mid-stall
    bus.IF_flush = 1'b0;
    bus.MemRead_ex = 1'b0;
    bus.Instruction_if = ADD_W;
    bus.PC_if = 32'h20;
    tick();
    bus.MemRead_ex = 1'b1;
    bus.Rd_ex = 5'd2;
    bus.Instruction_if = SW_W;
    bus.PC_if = 32'h24;
    #1;
    check("ar_bubble_pre", {31'b0, bus.Bubble_id}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_instr", bus.Instruction_id, NOP_W);
    check("ar_pc", bus.PC_id, 32'h0);
    check("ar_valid", {31'b0, bus.Valid_id}, 32'h0);
    check("ar_bubble", {31'b0, bus.Bubble_id}, 32'h0);
    check("ar_ifwrite", {31'b0, bus.IFWrite}, 32'h1);
    check("ar_stall", {16'b0, bus.StallCount}, 32'h0);
    check("ar_flush", {16'b0, bus.FlushCount}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("ar_resume_instr", bus.Instruction_id, SW_W);
    check("ar_resume_valid", {31'b0, bus.Valid_id}, 32'h1);

    // Flush counter saturation
    bus.MemRead_ex = 1'b0;
    bus.IF_flush = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_reach", {16'b0, bus.FlushCount}, 32'h0000FFFF);
    tick();
    tick();
    tick();
    check("sat_hold", {16'b0, bus.FlushCount}, 32'h0000FFFF);
    check("sat_stall", {16'b0, bus.StallCount}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register with integrated load-use hazard detection, directly downstream of the instruction-fetch stage. Captures fetched instruction and PC each cycle and presents them to decode. Squashes the register on a control-flow flush. Generates the `IFWrite` enable that freezes the PC register and the IF/ID register on a load-use hazard, plus a bubble request for ID/EX. Keeps saturating stall and flush event counters for debug.

## Interface

Parameters:
- `NOP`, 32'h00000013, instruction word loaded on reset and flush (`addi x0,x0,0`).
- `CNT_W`, 16, width of the stall and flush event counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Instruction_if`  in  32  instruction from fetch.
- `PC_if`  in  32  PC of `Instruction_if`.
- `IF_flush`  in  1  jump/branch taken; squash the IF/ID contents.
- `MemRead_ex`  in  1  instruction in EX is a load.
- `Rd_ex`  in  5  destination register of the EX instruction.
- `Instruction_id`  out  32  registered instruction to decode.
- `PC_id`  out  32  registered PC to decode.
- `Valid_id`  out  1  `Instruction_id` is a real, non-squashed instruction.
- `Rs1_id`, `Rs2_id`, `Rd_id`  out  5 each  fields [19:15], [24:20], [11:7] of `Instruction_id`.
- `IFWrite`  out  1  enable for the PC register and for this register.
- `Bubble_id`  out  1  ID/EX must load a bubble this cycle.
- `StallCount`  out  CNT_W  number of hazard-stall cycles, saturating.
- `FlushCount`  out  CNT_W  number of flush cycles, saturating.

## Operation

- Operand use is decoded from opcode `Instruction_id[6:0]`:
  - `uses_rs1` for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - `uses_rs2` for 0110011, 0100011, 1100011.
  - All other opcodes use neither.
- `hazard` = `Valid_id` & `MemRead_ex` & (`Rd_ex` != 0) & ((`uses_rs1` & `Rd_ex`==`Rs1_id`) | (`uses_rs2` & `Rd_ex`==`Rs2_id`)).
- `IFWrite` = ~`hazard` | `IF_flush`. A flush always releases the PC, so the jump target is never lost.
- `Bubble_id` = `hazard` & ~`IF_flush`.
- Register update at each rising edge, in priority order:
  1. `IF_flush`=1: `Instruction_id`<=`NOP`, `PC_id`<=`PC_if`, `Valid_id`<=0.
  2. else `hazard`=1: hold `Instruction_id`, `PC_id` and `Valid_id`.
  3. else: `Instruction_id`<=`Instruction_if`, `PC_id`<=`PC_if`, `Valid_id`<=1.
- Counters:
  - `StallCount` increments on each edge where `Bubble_id`=1.
  - `FlushCount` increments on each edge where `IF_flush`=1.
  - Both saturate at all-ones; they never wrap.
  - Both events in one cycle are impossible by construction: flush masks the bubble.
- Field outputs (`Rs1_id`, `Rs2_id`, `Rd_id`) are pure slices of the registered instruction.

## Timing

- Reset, asynchronous, while `reset`=0:
  - `Instruction_id`=`NOP`, `PC_id`=0, `Valid_id`=0, counters=0.
  - Hence `IFWrite`=1 and `Bubble_id`=0.
- Reset released mid-stall: state is already cleared, and fetch resumes on the first edge after release.
- Latency: an instruction presented on `Instruction_if` appears on `Instruction_id` one cycle later.
- `hazard`, `IFWrite` and `Bubble_id` are combinational from registered state and same-cycle EX inputs. There is no path from `Instruction_if`.
- A load-use stall lasts exactly one cycle:
  - The next cycle the load has left EX, so `MemRead_ex` refers to the bubble and deasserts.
  - The held instruction then advances.
- `IF_flush` squashes whatever fetch delivers in that cycle. `Valid_id`=0 for exactly one cycle per flush cycle.
- Back-to-back flushes keep `Valid_id`=0 throughout.

## Test plan

- Reset then stream: hold `reset`=0 for 2 cycles, release, drive `Instruction_if`=0x00500093 with `PC_if`=0x0.
  - During reset: `Instruction_id`=0x00000013, `Valid_id`=0, `IFWrite`=1.
  - One edge after the stream starts: `Instruction_id`=0x00500093, `PC_id`=0, `Valid_id`=1.
- Load-use on rs2: ID holds `add x3,x1,x2` (0x002081B3), with `MemRead_ex`=1 and `Rd_ex`=2.
  - Required: `IFWrite`=0, `Bubble_id`=1, ID contents held one cycle, `StallCount` 0→1.
  - After `MemRead_ex` drops, the add advances.
- No false hazard:
  - `Rd_ex`=0 → no stall.
  - `lui x5` (uses neither source) with `Rd_ex` matching bits [19:15] → no stall.
  - `Valid_id`=0 → no stall.
- Flush during hazard: hazard conditions true and `IF_flush`=1 together.
  - Required: `IFWrite`=1, `Bubble_id`=0.
  - Next cycle: `Instruction_id`=0x00000013, `Valid_id`=0, `FlushCount`+1, `StallCount` unchanged.
- Counter saturation: preload via 65535 flush cycles, then assert 3 more → `FlushCount` stays 0xFFFF.
- Asynchronous reset mid-stall: assert `reset`=0 between clock edges while `Bubble_id`=1.
  - Required: outputs clear immediately, without waiting for a clock edge.
